// File: rtl/aib_wb2apb_pkg.sv
// Shared types and constants for the AIB Wishbone-to-APB bridge.
// Timeout support in the top module is enabled with AIB_WB2APB_TIMEOUT_EN.
package aib_wb2apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } req_t;

   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/aib_wb2apb_fifo.sv
// Request FIFO for the AIB bridge: DEPTH entries of req_t, head is the oldest entry.
// Caller guarantees no push when full and no pop when empty.
module aib_wb2apb_fifo
   import aib_wb2apb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  req_t                     din,
   output req_t                     head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   req_t          mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; entries are only observed once counted.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/aib_wb2apb_bridge.sv
// Pipelined Wishbone to APB bridge for the AIB window; one in-order ack per accepted request.
// Optional ACCESS-phase timeout with sticky o_err is enabled by defining AIB_WB2APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer; waiting for a queued or incoming request
// SETUP  | psel high, APB fields driven from the FIFO head
// ACCESS | psel and penable high, waiting for pready (or timeout)
module aib_wb2apb_bridge
   import aib_wb2apb_pkg::*;
#(
   parameter int DEPTH       = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [31:0] i_wb_addr,
   input  logic [3:0]  i_wb_sel,
   input  logic [31:0] i_wb_wdata,
   output logic        o_wb_stall,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_rdata,
   output logic        o_psel,
   output logic        o_penable,
   output logic        o_pwrite,
   output logic [31:0] o_paddr,
   output logic [3:0]  o_pstrb,
   output logic [31:0] o_pwdata,
   input  logic        i_pready,
   input  logic [31:0] i_prdata,
   output logic        o_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   state_t          state;
   req_t            wreq;
   req_t            head;
   logic            full;
   logic            empty;
   logic [CW-1:0]   count;
   logic            push;
   logic            done;
   logic            timeout_hit;
   logic            psel_q;
   logic            penable_q;

   assign wreq.we    = i_wb_we;
   assign wreq.addr  = i_wb_addr;
   assign wreq.sel   = i_wb_sel;
   assign wreq.wdata = i_wb_wdata;

   assign o_wb_stall = full;
   assign push       = i_wb_stb && !full;
   assign done       = (state == ACCESS) && (i_pready || timeout_hit);

   aib_wb2apb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (push),
      .pop   (done),
      .din   (wreq),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         o_wb_ack   <= 1'b0;
         o_wb_rdata <= '0;
      end else begin
         o_wb_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty || push) begin
                  state  <= SETUP;
                  psel_q <= 1'b1;
               end
            end
            SETUP: begin
               state     <= ACCESS;
               penable_q <= 1'b1;
            end
            ACCESS: begin
               if (done) begin
                  o_wb_ack   <= 1'b1;
                  o_wb_rdata <= (!i_pready && timeout_hit) ? ERR_RDATA :
                                (head.we ? 32'h0 : i_prdata);
                  penable_q  <= 1'b0;
                  // Another entry left after this pop: chain straight into its SETUP.
                  if (count > CW'(1) || push) begin
                     state <= SETUP;
                  end else begin
                     state  <= IDLE;
                     psel_q <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
            end
         endcase
      end
   end

   // APB fields come straight from the FIFO head, which is stable until the pop.
   assign o_psel    = psel_q;
   assign o_penable = penable_q;
   assign o_pwrite  = psel_q && head.we;
   assign o_paddr   = psel_q ? head.addr : 32'h0;
   assign o_pstrb   = (psel_q && head.we) ? head.sel : 4'h0;
   assign o_pwdata  = psel_q ? head.wdata : 32'h0;

`ifdef AIB_WB2APB_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TW-1:0] tmo_cnt;
   logic          err_q;

   // Down-counter loaded in SETUP; terminal count marks the last allowed ACCESS cycle.
   assign timeout_hit = (state == ACCESS) && !i_pready && (tmo_cnt == '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state == SETUP) begin
            tmo_cnt <= TW'(TIMEOUT_CYC - 1);
         end else if (state == ACCESS && !i_pready && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TW'(1);
         end
         if (timeout_hit) err_q <= 1'b1;
      end
   end

   assign o_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_aib_wb2apb_bridge.sv
// Self-checking bench for aib_wb2apb_bridge: transaction-level scoreboard plus directed literal checks.
module tb_aib_wb2apb_bridge;

   localparam int DEPTH = 2;
   localparam int TO    = 8;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [31:0] i_wb_addr;
   logic [3:0]  i_wb_sel;
   logic [31:0] i_wb_wdata;
   logic        o_wb_stall;
   logic        o_wb_ack;
   logic [31:0] o_wb_rdata;
   logic        o_psel;
   logic        o_penable;
   logic        o_pwrite;
   logic [31:0] o_paddr;
   logic [3:0]  o_pstrb;
   logic [31:0] o_pwdata;
   logic        i_pready;
   logic [31:0] i_prdata;
   logic        o_err;

   aib_wb2apb_bridge #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wb_stb   (i_wb_stb),
      .i_wb_we    (i_wb_we),
      .i_wb_addr  (i_wb_addr),
      .i_wb_sel   (i_wb_sel),
      .i_wb_wdata (i_wb_wdata),
      .o_wb_stall (o_wb_stall),
      .o_wb_ack   (o_wb_ack),
      .o_wb_rdata (o_wb_rdata),
      .o_psel     (o_psel),
      .o_penable  (o_penable),
      .o_pwrite   (o_pwrite),
      .o_paddr    (o_paddr),
      .o_pstrb    (o_pstrb),
      .o_pwdata   (o_pwdata),
      .i_pready   (i_pready),
      .i_prdata   (i_prdata),
      .o_err      (o_err)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard model ----------------
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } mreq_t;

   mreq_t       q[$];
   mreq_t       f;
   logic        pend_ack = 1'b0;
   logic [31:0] pend_rd  = '0;
   logic        err_pend = 1'b0;
   logic        exp_err  = 1'b0;
   logic        prev_ack = 1'b0;
   logic        prev_psel = 1'b0;
   int          acc_k    = 0;
   int          ack_total = 0;
   logic        m_done;
   logic        m_to;

   always @(negedge i_clk) begin
      if (i_rst) begin
         q.delete();
         pend_ack = 1'b0; err_pend = 1'b0; exp_err = 1'b0;
         prev_ack = 1'b0; prev_psel = 1'b0; acc_k = 0;
         chk("rst_psel",  o_psel, 0);
         chk("rst_pen",   o_penable, 0);
         chk("rst_ack",   o_wb_ack, 0);
         chk("rst_stall", o_wb_stall, 0);
         chk("rst_paddr", o_paddr, 0);
         chk("rst_err",   o_err, 0);
      end else begin
         if (err_pend) exp_err = 1'b1;
         chk("ack", o_wb_ack, pend_ack);
         if (pend_ack) chk("rdata", o_wb_rdata, pend_rd);
         chk("ack_gap", prev_ack & o_wb_ack, 0);
         if (o_wb_ack) ack_total++;
         prev_ack = o_wb_ack;
         chk("stall", o_wb_stall, (q.size() == DEPTH));
         chk("err", o_err, exp_err);
         pend_ack = 1'b0;
         if (o_penable) chk("pen_without_psel", o_psel, 1);
         if (o_psel) begin
            if (q.size() == 0) begin
               chk("psel_no_request", o_psel, 0);
            end else begin
               f = q[0];
               chk("paddr",  o_paddr, f.addr);
               chk("pwrite", o_pwrite, f.we);
               chk("pstrb",  o_pstrb, f.we ? f.sel : 4'h0);
               chk("pwdata", o_pwdata, f.wdata);
               if (o_penable) begin
                  chk("setup_first", prev_psel, 1);
                  acc_k++;
                  m_done = i_pready;
                  m_to   = 1'b0;
`ifdef AIB_WB2APB_TIMEOUT_EN
                  if (!i_pready && acc_k == TO) begin
                     m_done = 1'b1;
                     m_to   = 1'b1;
                  end
`endif
                  if (m_done) begin
                     pend_ack = 1'b1;
                     pend_rd  = m_to ? 32'hDEAD_BEEF : (f.we ? 32'h0 : i_prdata);
                     if (m_to) err_pend = 1'b1;
                     void'(q.pop_front());
                     acc_k = 0;
                  end
               end
            end
         end
         prev_psel = o_psel;
         if (i_wb_stb && !o_wb_stall)
            q.push_back('{we: i_wb_we, addr: i_wb_addr, sel: i_wb_sel, wdata: i_wb_wdata});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wdata, output int stalls);
      logic acc;
      stalls = 0;
      acc = 1'b0;
      i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = addr; i_wb_sel = sel; i_wb_wdata = wdata;
      for (int n = 0; n < 100 && !acc; n++) begin
         if (!o_wb_stall) acc = 1'b1;
         else stalls++;
         tick();
      end
      i_wb_stb = 1'b0; i_wb_we = 1'b0;
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      logic idle;
      idle = 1'b0;
      for (int n = 0; n < 300 && !idle; n++) begin
         tick();
         if (q.size() == 0 && !pend_ack && !o_wb_ack && !o_psel) idle = 1'b1;
      end
      if (!idle) chk("drain_timeout", 0, 1);
   endtask

   task automatic wait_access();
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         if (o_psel && o_penable) seen = 1'b1;
         else tick();
      end
      if (!seen) chk("access_timeout", 0, 1);
   endtask

   task automatic pulse_reset();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      tick();
   endtask

   int st;
   int acks0;
   int ncyc;

   initial begin
      i_rst = 1'b1; i_wb_stb = 0; i_wb_we = 0; i_wb_addr = 0; i_wb_sel = 0; i_wb_wdata = 0;
      i_pready = 0; i_prdata = 0;
      repeat (2) tick();
      chk("reset_psel",  o_psel, 0);
      chk("reset_stall", o_wb_stall, 0);
      chk("reset_ack",   o_wb_ack, 0);
      i_rst = 1'b0;
      tick();

      // single read, pready immediately
      i_pready = 1'b1; i_prdata = 32'h1234_5678;
      i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 32'h1100_0010; i_wb_sel = 4'hF; i_wb_wdata = 0;
      tick();
      i_wb_stb = 0;
      chk("t1_c1_psel", o_psel, 1);
      chk("t1_c1_pen",  o_penable, 0);
      chk("t1_paddr",   o_paddr, 32'h1100_0010);
      tick();
      chk("t1_c2_pen",  o_penable, 1);
      chk("t1_c2_ack",  o_wb_ack, 0);
      tick();
      chk("t1_c3_ack",  o_wb_ack, 1);
      chk("t1_rdata",   o_wb_rdata, 32'h1234_5678);
      chk("t1_c3_psel", o_psel, 0);
      repeat (2) tick();

      // write, pready in the 4th ACCESS cycle
      i_pready = 1'b0; i_prdata = 32'hFFFF_0000;
      i_wb_stb = 1; i_wb_we = 1; i_wb_addr = 32'h1100_0020; i_wb_sel = 4'b0011;
      i_wb_wdata = 32'hA5A5_A5A5;
      tick();
      i_wb_stb = 0; i_wb_we = 0;
      tick();
      chk("t2_pstrb",  o_pstrb, 4'b0011);
      chk("t2_pwrite", o_pwrite, 1);
      chk("t2_pen",    o_penable, 1);
      repeat (2) begin
         tick();
         chk("t2_hold_pen",   o_penable, 1);
         chk("t2_hold_pdata", o_pwdata, 32'hA5A5_A5A5);
      end
      tick();
      i_pready = 1'b1;
      chk("t2_noack_before", o_wb_ack, 0);
      tick();
      i_pready = 1'b0;
      chk("t2_ack",   o_wb_ack, 1);
      chk("t2_rdata", o_wb_rdata, 32'h0);
      repeat (2) tick();

      // three back-to-back requests into a 2-deep FIFO
      i_prdata = 32'h0BAD_F00D;
      acks0 = ack_total;
      fork
         begin
            send(0, 32'h1100_0100, 4'hF, 0, st);
            chk("t3_a_stall", st, 0);
            send(0, 32'h1100_0104, 4'hF, 0, st);
            chk("t3_b_stall", st, 0);
            send(0, 32'h1100_0108, 4'hF, 0, st);
            chk("t3_c_stall", st, 3);
         end
         begin
            repeat (4) tick();
            i_pready = 1'b1;
         end
      join
      drain();
      chk("t3_acks", ack_total - acks0, 3);
      i_pready = 1'b0;

      // reset during ACCESS of the second queued request
      i_prdata = 32'h7777_0000;
      send(0, 32'h1100_0200, 4'hF, 0, st);
      send(0, 32'h1100_0204, 4'hF, 0, st);
      wait_access();
      i_pready = 1'b1;
      tick();
      i_pready = 1'b0;
      wait_access();
      i_rst = 1'b1;
      #1;
      chk("t4_psel",  o_psel, 0);
      chk("t4_pen",   o_penable, 0);
      chk("t4_paddr", o_paddr, 0);
      chk("t4_ack",   o_wb_ack, 0);
      chk("t4_stall", o_wb_stall, 0);
      tick();
      i_rst = 1'b0;
      acks0 = ack_total;
      repeat (6) tick();
      chk("t4_no_ack", ack_total - acks0, 0);
      i_pready = 1'b1; i_prdata = 32'hCAFE_0001;
      send(0, 32'h1100_0300, 4'hF, 0, st);
      drain();
      chk("t4_recover", ack_total - acks0, 1);
      i_pready = 1'b0;

`ifdef AIB_WB2APB_TIMEOUT_EN
      pulse_reset();
      // timeout after TO ACCESS cycles
      i_prdata = 32'h1111_2222;
      send(0, 32'h1100_0400, 4'hF, 0, st);
      ncyc = 1;
      while (!o_wb_ack && ncyc < 40) begin
         tick();
         ncyc++;
      end
      chk("t5_ack_cycle", ncyc, 10);
      chk("t5_rdata", o_wb_rdata, 32'hDEAD_BEEF);
      tick();
      chk("t5_err", o_err, 1);
      i_pready = 1'b1; i_prdata = 32'h3333_4444;
      send(0, 32'h1100_0404, 4'hF, 0, st);
      drain();
      chk("t5_err_sticky", o_err, 1);
      i_pready = 1'b0;
      pulse_reset();

      // pready on the timeout cycle wins
      i_prdata = 32'h5555_6666;
      send(0, 32'h1100_0408, 4'hF, 0, st);
      repeat (8) tick();
      i_pready = 1'b1;
      tick();
      i_pready = 1'b0;
      chk("t6_ack",   o_wb_ack, 1);
      chk("t6_rdata", o_wb_rdata, 32'h5555_6666);
      tick();
      chk("t6_err", o_err, 0);
      drain();
`endif

      chk("final_err", o_err, exp_err);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
